glitch_timing_ctrl: RTL and testbench
=====================================

GLITCH_TIMING_CTRL -- requirements
Module: glitch_timing_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of all timing inputs, internal counters and glitch_cnt.
REQ-002 clk  input  1  single system clock; all state changes on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 glitch_en  input  1  arms the sequencer; low aborts any sequence in progress.
REQ-005 glitch_width  input  CNT_W  glitch_gate high time per pulse, in cycles.
REQ-006 glitch_period  input  CNT_W  start-to-start pulse spacing, in cycles; 0 selects single shot.
REQ-007 glitch_pos  input  CNT_W  cycles from trigger detection to first pulse.
REQ-008 glitch_pos_fine  input  CNT_W  fine delay-line tap value, passed through on fine_delay.
REQ-009 trigger  input  1  target trigger, already synchronous to clk.
REQ-010 glitch_gate  output  1  registered glitch-clock mux select; high = glitchy clock selected.
REQ-011 fine_delay  output  CNT_W  glitch_pos_fine captured at trigger detection.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse on normal sequence completion.
REQ-014 glitch_cnt  output  CNT_W  pulses issued since the last accepted trigger, saturating at all-ones.

Function
REQ-015 The block SHALL register trigger into trig_d every cycle; a rising edge is trigger=1 and trig_d=0.
REQ-016 States SHALL be IDLE, DELAY, PULSE, GAP, DONE.
REQ-017 In IDLE, when a rising edge coincides with glitch_en=1 (edge T0), the block SHALL do all of the following at T0:
- capture width, period, pos and pos_fine into shadow registers;
- drive fine_delay from the captured pos_fine;
- clear glitch_cnt;
- enter DELAY.
REQ-018 Parameter-input changes after T0 SHALL NOT affect the running sequence.
REQ-019 glitch_gate SHALL first rise at edge T0+pos+1 (pos=0 gives T0+1) and remain high for exactly width cycles, in state PULSE.
REQ-020 glitch_cnt SHALL increment by one at the edge where each pulse's glitch_gate rises.
REQ-021 If width=0, the block SHALL go from DELAY to DONE with no pulse and glitch_cnt=0.
REQ-022 After a pulse, if period > width, period != 0 and trigger=1, the block SHALL enter GAP.
- GAP holds glitch_gate low for period-width cycles.
- The next pulse rises exactly period cycles after the previous rise.
REQ-023 If period=0, or period<=width, operation SHALL be single shot: after one pulse, go to DONE.
REQ-024 Trigger is sampled on the last pulse cycle; if trigger=0 there, the block SHALL go to DONE instead of GAP.
REQ-025 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-026 Rising edges of trigger while busy=1 SHALL be ignored, with no queuing.
REQ-027 glitch_en=0 in any non-IDLE state SHALL abort the sequence:
- next edge: IDLE, glitch_gate=0;
- done SHALL NOT pulse;
- glitch_cnt and fine_delay hold their values.
REQ-028 Counters SHALL be CNT_W bits, count down from loaded values, and never wrap; glitch_cnt saturates at all-ones.
REQ-029 A rising edge in IDLE with glitch_en=0 SHALL be discarded; it does not fire later when glitch_en rises.

Reset
REQ-030 While rst=1, the block SHALL immediately and asynchronously force:
- state=IDLE;
- glitch_gate=0, busy=0, done=0;
- glitch_cnt=0, fine_delay=0, shadow registers=0;
- trig_d=1.
REQ-031 Because trig_d resets to 1, a trigger held high through reset release SHALL NOT start a sequence; a fresh low-to-high transition is required.
REQ-032 Reset asserted mid-sequence SHALL drop glitch_gate within the same cycle, without waiting for clk.

Verification
REQ-033 en=1, pos=3, width=2, period=0; trigger rises at T0 -> gate high during T0+4..T0+5, done at T0+6, glitch_cnt=1, fine_delay=pos_fine.
REQ-034 en=1, pos=0, width=1, period=4; trigger held high for 3 pulses then low -> gate rises at T0+1, T0+5, T0+9; glitch_cnt=3; done one cycle after the last pulse.
REQ-035 width=0, pos=5 -> no gate activity; done at T0+6; glitch_cnt=0.
REQ-036 period=2, width=5 -> single 5-cycle pulse; second trigger edge during busy is ignored; glitch_cnt=1.
REQ-037 glitch_en dropped during the second PULSE of a periodic run -> gate low next edge; no done; glitch_cnt=2; busy=0.
REQ-038 Two reset cases:
- rst asserted mid-PULSE -> gate=0 with no clk edge;
- trigger held high across reset release -> no sequence until trigger toggles low then high.

Source files
------------

// File: rtl/glitch_timing_ctrl.sv
// Glitch timing sequencer: on a trigger rising edge, waits pos cycles, then
// issues width-cycle gate pulses every period cycles while trigger stays high.
// Latency: first gate rise at T0+pos+1; glitch_gate is registered.
// Backpressure: none. Trigger edges while busy are dropped, not queued.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   glitch_en           arm; low aborts a running sequence
//   glitch_width        gate high time per pulse (cycles)
//   glitch_period       start-to-start pulse spacing (0 = single shot)
//   glitch_pos          trigger-to-first-pulse delay (cycles)
//   glitch_pos_fine     fine delay tap, captured onto fine_delay at trigger
//   trigger             target trigger, synchronous to clk
//   glitch_gate         glitch clock mux select (registered)
//   fine_delay          captured glitch_pos_fine
//   busy                high outside IDLE
//   done                one-cycle pulse on normal completion
//   glitch_cnt          pulses since last accepted trigger, saturating
module glitch_timing_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             glitch_en,
    input  logic [CNT_W-1:0] glitch_width,
    input  logic [CNT_W-1:0] glitch_period,
    input  logic [CNT_W-1:0] glitch_pos,
    input  logic [CNT_W-1:0] glitch_pos_fine,
    input  logic             trigger,
    output logic             glitch_gate,
    output logic [CNT_W-1:0] fine_delay,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] glitch_cnt
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        PULSE,
        GAP,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] width_sh;
    logic [CNT_W-1:0] period_sh;
    logic             trig_d;
    logic             trig_rise;
    logic             capture;
    logic             pulse_start;

    assign trig_rise = trigger & ~trig_d;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    // Single down counter reused per state. The delay count is loaded
    // straight from glitch_pos at capture, so the counter itself is the
    // shadow copy of pos for the rest of the sequence.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        capture     = 1'b0;
        pulse_start = 1'b0;
        case (state)
            IDLE: begin
                if (trig_rise && glitch_en) begin
                    capture   = 1'b1;
                    cnt_nxt   = glitch_pos;
                    state_nxt = DELAY;
                end
            end
            DELAY: begin
                if (!glitch_en) begin
                    state_nxt = IDLE;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - ONE;
                end else if (width_sh == '0) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt   = PULSE;
                    cnt_nxt     = width_sh - ONE;
                    pulse_start = 1'b1;
                end
            end
            PULSE: begin
                if (!glitch_en) begin
                    state_nxt = IDLE;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - ONE;
                end else if (trigger && (period_sh != '0) && (period_sh > width_sh)) begin
                    // Gap of period-width cycles keeps rises exactly period apart.
                    state_nxt = GAP;
                    cnt_nxt   = period_sh - width_sh - ONE;
                end else begin
                    state_nxt = DONE;
                end
            end
            GAP: begin
                if (!glitch_en) begin
                    state_nxt = IDLE;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - ONE;
                end else begin
                    state_nxt   = PULSE;
                    cnt_nxt     = width_sh - ONE;
                    pulse_start = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            width_sh    <= '0;
            period_sh   <= '0;
            fine_delay  <= '0;
            glitch_cnt  <= '0;
            glitch_gate <= 1'b0;
            // Resetting to 1 means a trigger already high at reset release
            // does not count as a rising edge.
            trig_d      <= 1'b1;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            trig_d      <= trigger;
            glitch_gate <= (state_nxt == PULSE);
            if (capture) begin
                width_sh   <= glitch_width;
                period_sh  <= glitch_period;
                fine_delay <= glitch_pos_fine;
                glitch_cnt <= '0;
            end else if (pulse_start && (glitch_cnt != '1)) begin
                glitch_cnt <= glitch_cnt + ONE;
            end
        end
    end

endmodule

// File: tb/tb_glitch_timing_ctrl.sv
// Directed bench for glitch_timing_ctrl: per-cycle traces of gate/done/busy
// after the trigger edge T0, compared against hand-computed bit masks
// (bit k = value after edge T0+k), plus reset and discard cases.
module tb_glitch_timing_ctrl;

    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             glitch_en;
    logic [CNT_W-1:0] glitch_width;
    logic [CNT_W-1:0] glitch_period;
    logic [CNT_W-1:0] glitch_pos;
    logic [CNT_W-1:0] glitch_pos_fine;
    logic             trigger;
    logic             glitch_gate;
    logic [CNT_W-1:0] fine_delay;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] glitch_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] g_tr;
    logic [31:0] d_tr;
    logic [31:0] b_tr;

    glitch_timing_ctrl #(.CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .glitch_en       (glitch_en),
        .glitch_width    (glitch_width),
        .glitch_period   (glitch_period),
        .glitch_pos      (glitch_pos),
        .glitch_pos_fine (glitch_pos_fine),
        .trigger         (trigger),
        .glitch_gate     (glitch_gate),
        .fine_delay      (fine_delay),
        .busy            (busy),
        .done            (done),
        .glitch_cnt      (glitch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_params(input int pos, input int width, input int period, input int fine);
        glitch_pos      = CNT_W'(pos);
        glitch_width    = CNT_W'(width);
        glitch_period   = CNT_W'(period);
        glitch_pos_fine = CNT_W'(fine);
    endtask

    // Called at a negedge with trigger low. Raises trigger so the next posedge
    // is T0, then records outputs after each edge T0+k. Parameter inputs are
    // scrambled right after T0 to show they are no longer used.
    task automatic run_seq(input int ncyc, input int trig_off_k, input int en_off_k,
                           input int retrig_k,
                           output logic [31:0] gt, output logic [31:0] dt,
                           output logic [31:0] bt);
        gt = '0;
        dt = '0;
        bt = '0;
        trigger = 1'b1;
        @(negedge clk);
        for (int k = 0; k < ncyc; k++) begin
            gt[k] = glitch_gate;
            dt[k] = done;
            bt[k] = busy;
            if (k == 0) set_params(1, 7, 3, 16'hFFFF);
            if (k == trig_off_k) trigger = 1'b0;
            if (k == retrig_k)   trigger = 1'b1;
            if (k == en_off_k)   glitch_en = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        rst       = 1'b1;
        glitch_en = 1'b0;
        trigger   = 1'b0;
        set_params(0, 0, 0, 0);
        #12;
        check("reset gate", {31'b0, glitch_gate}, 32'd0);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset cnt",  {16'b0, glitch_cnt}, 32'd0);
        check("reset fine", {16'b0, fine_delay}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        glitch_en = 1'b1;
        repeat (2) @(negedge clk);

        // A: pos=3 width=2 single shot
        set_params(3, 2, 0, 16'h005A);
        run_seq(12, 0, -1, -1, g_tr, d_tr, b_tr);
        check("A gate", g_tr, 32'h30);
        check("A done", d_tr, 32'h40);
        check("A busy", b_tr, 32'h7F);
        check("A cnt",  {16'b0, glitch_cnt}, 32'd1);
        check("A fine", {16'b0, fine_delay}, 32'h5A);

        // B: pos=0 width=1 period=4, trigger high for three pulses
        set_params(0, 1, 4, 16'h0011);
        run_seq(14, 9, -1, -1, g_tr, d_tr, b_tr);
        check("B gate", g_tr, 32'h222);
        check("B done", d_tr, 32'h400);
        check("B busy", b_tr, 32'h7FF);
        check("B cnt",  {16'b0, glitch_cnt}, 32'd3);

        // C: width=0 pos=5, no pulse
        set_params(5, 0, 0, 16'h0022);
        run_seq(12, 0, -1, -1, g_tr, d_tr, b_tr);
        check("C gate", g_tr, 32'h0);
        check("C done", d_tr, 32'h40);
        check("C busy", b_tr, 32'h7F);
        check("C cnt",  {16'b0, glitch_cnt}, 32'd0);

        // D: period<=width single shot, re-trigger while busy ignored
        set_params(0, 5, 2, 16'h0033);
        run_seq(14, 0, -1, 2, g_tr, d_tr, b_tr);
        check("D gate", g_tr, 32'h3E);
        check("D done", d_tr, 32'h40);
        check("D busy", b_tr, 32'h7F);
        check("D cnt",  {16'b0, glitch_cnt}, 32'd1);
        trigger = 1'b0;
        repeat (2) @(negedge clk);

        // E: abort with glitch_en low during second pulse
        set_params(0, 2, 4, 16'h0044);
        run_seq(12, 5, 5, -1, g_tr, d_tr, b_tr);
        check("E gate", g_tr, 32'h26);
        check("E done", d_tr, 32'h0);
        check("E busy", b_tr, 32'h3F);
        check("E cnt",  {16'b0, glitch_cnt}, 32'd2);
        check("E fine", {16'b0, fine_delay}, 32'h44);
        glitch_en = 1'b1;
        repeat (2) @(negedge clk);

        // F: edge while disarmed is discarded
        set_params(0, 1, 0, 0);
        glitch_en = 1'b0;
        trigger = 1'b1;
        repeat (2) @(negedge clk);
        check("F busy disarmed", {31'b0, busy}, 32'd0);
        glitch_en = 1'b1;
        repeat (3) @(negedge clk);
        check("F busy late arm", {31'b0, busy}, 32'd0);
        trigger = 1'b0;
        repeat (2) @(negedge clk);

        // G: async reset mid-pulse, then trigger held through reset release
        set_params(0, 8, 0, 16'h0055);
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        repeat (2) @(negedge clk);
        check("G gate pre-rst", {31'b0, glitch_gate}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("G gate async", {31'b0, glitch_gate}, 32'd0);
        check("G busy async", {31'b0, busy}, 32'd0);
        check("G cnt async",  {16'b0, glitch_cnt}, 32'd0);
        check("G fine async", {16'b0, fine_delay}, 32'd0);
        trigger = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("G held trig", {31'b0, busy}, 32'd0);
        trigger = 1'b0;
        @(negedge clk);
        trigger = 1'b1;
        @(negedge clk);
        check("G fresh edge", {31'b0, busy}, 32'd1);
        trigger = 1'b0;
        repeat (15) @(negedge clk);
        check("G end busy", {31'b0, busy}, 32'd0);
        check("G end cnt",  {16'b0, glitch_cnt}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
